oled_pixel_streamer: RTL and testbench

- Requester side of the OLED pixel interface that the visualiser front-ends answer.
- Scans a 96x64 frame in raster order and drives pixel_index, frame_begin, sample_pixel and sending_pixels.
- Captures the 16-bit RGB565 pixel_data returned combinationally by the front-end and shifts it MSB-first to the panel on cs/sdin/sclk/d_cn.
- Panel power-up and command initialisation are owned by a separate init sequencer; this block starts streaming only when enable is asserted.

---
 rtl/oled_pkg.sv | 31 +++
 rtl/spi_tx_shifter.sv | 82 ++++++++
 rtl/oled_pixel_streamer.sv | 172 +++++++++++++++++
 tb/tb_oled_pixel_streamer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// ---------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the OLED pixel streaming path: panel geometry,
// RGB565 colour constants used by the visualiser front-ends, the streamer
// state encoding and a small geometry helper.
// ---------------------------------------------------------------------------
package oled_pkg;

  localparam int OLED_WIDTH    = 96;
  localparam int OLED_HEIGHT   = 64;
  localparam int NUM_PIXELS    = 6144;
  localparam int PIXEL_INDEX_W = 13;

  localparam logic [15:0] RGB565_BLACK  = 16'h0000;
  localparam logic [15:0] RGB565_GREEN  = 16'h07E0;
  localparam logic [15:0] RGB565_YELLOW = 16'hFFE0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SHIFT = 2'd3
  } stream_state_e;

  // Raster index of the final pixel of a width x height frame.
  function automatic logic [PIXEL_INDEX_W-1:0] last_pixel_index(input int width,
                                                                 input int height);
    return PIXEL_INDEX_W'(width * height - 1);
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// ---------------------------------------------------------------------------
// spi_tx_shifter
// 16-bit MSB-first serialiser for the panel link (SPI mode 3, sclk idles
// high). Each bit spends CLK_DIV cycles with sclk low (sdin changes on entry
// to the low phase) followed by CLK_DIV cycles with sclk high.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   load          capture data and start a 16-bit transfer at this edge
//   data          word to transmit
//   busy          transfer in progress (registered)
//   done          high in the final cycle of the last high phase
//   sclk, sdin    serial clock and data (registered)
// ---------------------------------------------------------------------------
module spi_tx_shifter #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] data,
  output logic        busy,
  output logic        done,
  output logic        sclk,
  output logic        sdin
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

  logic [15:0]      shreg_r;
  logic [3:0]       bit_cnt_r;   // bits still to send after the current one
  logic [DIV_W-1:0] div_cnt_r;   // cycles left in the current sclk phase
  logic             busy_r;
  logic             sclk_r;
  logic             sdin_r;

  // Load, phase timing and bit shifting of the outgoing word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_r   <= 16'h0000;
      bit_cnt_r <= 4'd0;
      div_cnt_r <= DIV_ZERO;
      busy_r    <= 1'b0;
      sclk_r    <= 1'b1;
      sdin_r    <= 1'b0;
    end else if (load) begin
      shreg_r   <= data;
      sdin_r    <= data[15];
      sclk_r    <= 1'b0;
      bit_cnt_r <= 4'd15;
      div_cnt_r <= DIV_INIT;
      busy_r    <= 1'b1;
    end else if (busy_r) begin
      if (div_cnt_r != DIV_ZERO) begin
        div_cnt_r <= div_cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
      end else begin
        div_cnt_r <= DIV_INIT;
        if (!sclk_r) begin
          sclk_r <= 1'b1;
        end else if (bit_cnt_r != 4'd0) begin
          // Falling edge: present the next bit for the panel's rising edge.
          sclk_r    <= 1'b0;
          bit_cnt_r <= bit_cnt_r - 4'd1;
          shreg_r   <= {shreg_r[14:0], 1'b0};
          sdin_r    <= shreg_r[14];
        end else begin
          // Last high phase finished; sclk stays high as the idle level.
          busy_r <= 1'b0;
          sdin_r <= 1'b0;
        end
      end
    end
  end

  assign busy = busy_r;
  assign done = busy_r & sclk_r & (bit_cnt_r == 4'd0) & (div_cnt_r == DIV_ZERO);
  assign sclk = sclk_r;
  assign sdin = sdin_r;

endmodule

// File: rtl/oled_pixel_streamer.sv
// ---------------------------------------------------------------------------
// oled_pixel_streamer
// Requester side of the OLED pixel interface. Scans a WIDTH x HEIGHT frame
// in raster order, asks the front-end for each pixel via pixel_index /
// sample_pixel, captures the RGB565 reply and streams it to the panel.
// Frames are separated by FRAME_GAP+1 cycles of cs high plus a one-cycle
// frame_begin pulse. enable is only looked at in IDLE and at frame end.
//
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   enable          panel initialisation complete (level)
//   pixel_data      RGB565 colour for pixel_index (combinational reply)
//   frame_begin     one-cycle pulse before the first pixel of a frame
//   sending_pixels  high while a frame is on the wire
//   sample_pixel    pixel_data is captured at the end of this cycle
//   pixel_index     current raster index
//   cs, sdin, sclk  panel serial link (cs active low, sclk idle high)
//   d_cn            data/command select, 1 = pixel data
// ---------------------------------------------------------------------------
module oled_pixel_streamer
  import oled_pkg::*;
#(
  parameter int WIDTH     = OLED_WIDTH,
  parameter int HEIGHT    = OLED_HEIGHT,
  parameter int CLK_DIV   = 1,
  parameter int FRAME_GAP = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] pixel_data,
  output logic        frame_begin,
  output logic        sending_pixels,
  output logic        sample_pixel,
  output logic [12:0] pixel_index,
  output logic        cs,
  output logic        sdin,
  output logic        sclk,
  output logic        d_cn
);

  localparam logic [12:0]      LAST_INDEX = last_pixel_index(WIDTH, HEIGHT);
  localparam int               GAP_W      = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT   = GAP_W'(FRAME_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ZERO   = {GAP_W{1'b0}};

  stream_state_e    state_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             gap_done_r;     // counter has reached zero
  logic             frame_begin_r;
  logic             sample_pixel_r;
  logic             sending_r;
  logic [12:0]      pixel_index_r;
  logic             cs_r;
  logic             d_cn_r;

  logic             tx_load_s;
  logic             tx_busy_s;
  logic             tx_done_s;

  // The shifter captures pixel_data on the single LOAD cycle.
  assign tx_load_s = (state_r == ST_LOAD);

  spi_tx_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tx_load_s),
    .data    (pixel_data),
    .busy    (tx_busy_s),
    .done    (tx_done_s),
    .sclk    (sclk),
    .sdin    (sdin)
  );

  // Frame sequencing FSM with registered interface outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      gap_cnt_r      <= GAP_ZERO;
      gap_done_r     <= 1'b0;
      frame_begin_r  <= 1'b0;
      sample_pixel_r <= 1'b0;
      sending_r      <= 1'b0;
      pixel_index_r  <= 13'd0;
      cs_r           <= 1'b1;
      d_cn_r         <= 1'b0;
    end else begin
      frame_begin_r  <= 1'b0;
      sample_pixel_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            state_r    <= ST_GAP;
            gap_cnt_r  <= GAP_INIT;
            gap_done_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_GAP: begin
          // Count down, spend one more cycle after zero, then pulse
          // frame_begin in its own cycle so it never meets sample_pixel.
          if (gap_cnt_r != GAP_ZERO) begin
            gap_cnt_r <= gap_cnt_r - {{(GAP_W-1){1'b0}}, 1'b1};
          end else if (!gap_done_r) begin
            gap_done_r <= 1'b1;
          end else if (!frame_begin_r) begin
            frame_begin_r <= 1'b1;
            pixel_index_r <= 13'd0;
          end else begin
            gap_done_r     <= 1'b0;
            state_r        <= ST_LOAD;
            sample_pixel_r <= 1'b1;
            cs_r           <= 1'b0;
            d_cn_r         <= 1'b1;
            sending_r      <= 1'b1;
          end
        end

        ST_LOAD: begin
          state_r <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (tx_done_s) begin
            if (pixel_index_r != LAST_INDEX) begin
              pixel_index_r  <= pixel_index_r + 13'd1;
              state_r        <= ST_LOAD;
              sample_pixel_r <= 1'b1;
            end else begin
              // Frame complete: release the panel and decide on the next frame.
              pixel_index_r <= 13'd0;
              cs_r          <= 1'b1;
              d_cn_r        <= 1'b0;
              sending_r     <= 1'b0;
              gap_cnt_r     <= GAP_INIT;
              gap_done_r    <= 1'b0;
              state_r       <= enable ? ST_GAP : ST_IDLE;
            end
          end else if (!tx_busy_s) begin
            // Shifter idle without finishing a word: resend the current pixel
            // rather than stall with cs low.
            state_r        <= ST_LOAD;
            sample_pixel_r <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
          end
        end

        default: begin
          state_r       <= ST_IDLE;
          pixel_index_r <= 13'd0;
          cs_r          <= 1'b1;
          d_cn_r        <= 1'b0;
          sending_r     <= 1'b0;
          gap_done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign frame_begin    = frame_begin_r;
  assign sample_pixel   = sample_pixel_r;
  assign sending_pixels = sending_r;
  assign pixel_index    = pixel_index_r;
  assign cs             = cs_r;
  assign d_cn           = d_cn_r;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// ---------------------------------------------------------------------------
// tb_oled_pixel_streamer
// Directed bench for oled_pixel_streamer on a reduced 12x4 frame. A model
// front-end answers pixel_index, a serial monitor rebuilds words from the
// panel link, and each step compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_oled_pixel_streamer;

  localparam int TB_WIDTH  = 12;
  localparam int TB_HEIGHT = 4;
  localparam int TB_PIXELS = TB_WIDTH * TB_HEIGHT;   // last index 47

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] pixel_data;
  logic        frame_begin;
  logic        sending_pixels;
  logic        sample_pixel;
  logic [12:0] pixel_index;
  logic        cs;
  logic        sdin;
  logic        sclk;
  logic        d_cn;

  int tests = 0;
  int fails = 0;
  int mode  = 0;
  int fb_cnt = 0;
  int overlap_cnt = 0;
  int sclk_viol = 0;

  logic [15:0] words_q[$];
  logic [15:0] mon_bits = 16'h0000;
  int          mon_nbits = 0;

  always #5 clk = ~clk;

  oled_pixel_streamer #(
    .WIDTH     (TB_WIDTH),
    .HEIGHT    (TB_HEIGHT),
    .CLK_DIV   (1),
    .FRAME_GAP (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .pixel_data     (pixel_data),
    .frame_begin    (frame_begin),
    .sending_pixels (sending_pixels),
    .sample_pixel   (sample_pixel),
    .pixel_index    (pixel_index),
    .cs             (cs),
    .sdin           (sdin),
    .sclk           (sclk),
    .d_cn           (d_cn)
  );

  // Front-end model: combinational colour for the requested index.
  always_comb begin
    case (mode)
      0: begin
        if (pixel_index == 13'd0)      pixel_data = 16'hFFE0;
        else if (pixel_index == 13'd1) pixel_data = 16'h07E0;
        else                           pixel_data = {3'b000, pixel_index};
      end
      1:       pixel_data = {3'b000, pixel_index};
      default: pixel_data = 16'hFFE0;
    endcase
  end

  // Serial monitor: sample sdin on sclk rising edges while cs is low.
  always @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      mon_nbits <= 0;
      mon_bits  <= 16'h0000;
    end else if (cs === 1'b0) begin
      mon_bits <= {mon_bits[14:0], sdin};
      if (mon_nbits == 15) begin
        words_q.push_back({mon_bits[14:0], sdin});
        mon_nbits <= 0;
      end else begin
        mon_nbits <= mon_nbits + 1;
      end
    end
  end

  // Pulse bookkeeping sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_begin === 1'b1) fb_cnt <= fb_cnt + 1;
    if (frame_begin === 1'b1 && sample_pixel === 1'b1) overlap_cnt <= overlap_cnt + 1;
  end

  // Any sclk movement while the panel is deselected is a protocol error.
  always @(sclk) begin
    if (reset_n === 1'b1 && cs === 1'b1) sclk_viol <= sclk_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait until frame_begin (0), sample_pixel (1) or cs (2) is high; n = ticks taken.
  task automatic wait_sig(input int which, input int limit, output int n);
    logic hit;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = frame_begin;
        1:       hit = sample_pixel;
        default: hit = cs;
      endcase
    end while (hit !== 1'b1 && n < limit);
  endtask

  // Wait for the LOAD cycle of a given pixel index.
  task automatic wait_index(input logic [12:0] idx, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sample_pixel === 1'b1 && pixel_index === idx) && n < limit);
  endtask

  initial begin
    int n;
    int bad;
    logic cs_seen;

    // Reset state
    reset_n = 1'b0;
    enable  = 1'b0;
    mode    = 0;
    tick(2);
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 1);
    check("rst_sdin", sdin, 0);
    check("rst_dcn", d_cn, 0);
    check("rst_fb", frame_begin, 0);
    check("rst_sp", sample_pixel, 0);
    check("rst_send", sending_pixels, 0);
    check("rst_idx", pixel_index, 0);

    // Released with enable low: nothing happens
    reset_n = 1'b1;
    tick(100);
    check("idle_cs", cs, 1);
    check("idle_sclk", sclk, 1);
    check("idle_send", sending_pixels, 0);
    check("idle_fb_cnt", fb_cnt, 0);
    check("idle_idx", pixel_index, 0);

    // Frame 1: gap timing, first LOAD, pixel spacing, decoded colours
    enable = 1'b1;
    wait_sig(0, 100, n);
    check("gap_to_fb", n, 18);
    check("fb_cs", cs, 1);
    check("fb_idx", pixel_index, 0);
    tick(1);
    check("load_sp", sample_pixel, 1);
    check("load_fb", frame_begin, 0);
    check("load_idx", pixel_index, 0);
    check("load_cs", cs, 0);
    check("load_dcn", d_cn, 1);
    check("load_send", sending_pixels, 1);

    cs_seen = 1'b0;
    n = 0;
    do begin
      tick(1);
      n++;
      if (cs !== 1'b0) cs_seen = 1'b1;
    end while (sample_pixel !== 1'b1 && n < 100);
    check("strobe_gap", n, 33);
    check("cs_low_between", cs_seen, 0);
    check("idx_1", pixel_index, 1);

    wait_sig(2, TB_PIXELS * 33 + 100, n);
    check("end1_cs", cs, 1);
    check("end1_send", sending_pixels, 0);
    check("end1_dcn", d_cn, 0);
    check("end1_idx", pixel_index, 0);
    check("end1_count", words_q.size(), TB_PIXELS);
    check("w0_yellow", words_q[0], 16'hFFE0);
    check("w1_green", words_q[1], 16'h07E0);
    check("w2", words_q[2], 16'h0002);
    check("w47", words_q[47], 16'h002F);

    // Frame 2: index-valued pixels, all words in order
    mode = 1;
    words_q.delete();
    wait_sig(0, 100, n);
    check("gap1_to_fb", n, 17);
    check("fb2_idx", pixel_index, 0);
    wait_sig(2, TB_PIXELS * 33 + 100, n);
    check("end2_cs", cs, 1);
    check("end2_count", words_q.size(), TB_PIXELS);
    bad = 0;
    for (int i = 0; i < words_q.size(); i++) begin
      if (words_q[i] !== 16'(i)) bad++;
    end
    check("end2_order", bad, 0);

    // Frame 3: enable dropped mid-frame, frame still completes
    words_q.delete();
    wait_index(13'd20, 2000, n);
    check("drop_at_idx", pixel_index, 20);
    enable = 1'b0;
    wait_sig(2, TB_PIXELS * 33 + 100, n);
    check("end3_cs", cs, 1);
    check("end3_count", words_q.size(), TB_PIXELS);
    check("end3_last", words_q[TB_PIXELS-1], 16'h002F);
    tick(100);
    check("no_restart_fb", fb_cnt, 3);
    check("after_cs", cs, 1);
    check("after_sclk", sclk, 1);
    check("after_send", sending_pixels, 0);

    // Asynchronous reset in the middle of pixel 10, bit 7
    mode   = 2;
    enable = 1'b1;
    wait_index(13'd10, 18 + 11 * 33 + 100, n);
    check("rst_at_idx", pixel_index, 10);
    tick(17);
    check("pre_rst_sclk", sclk, 0);
    check("pre_rst_sdin", sdin, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_cs", cs, 1);
    check("mid_rst_sclk", sclk, 1);
    check("mid_rst_sdin", sdin, 0);
    check("mid_rst_send", sending_pixels, 0);
    check("mid_rst_idx", pixel_index, 0);
    tick(2);
    mode = 1;
    words_q.delete();
    reset_n = 1'b1;
    wait_sig(0, 100, n);
    check("rst_to_fb", n, 18);
    tick(1);
    check("rst_load_sp", sample_pixel, 1);
    check("rst_load_idx", pixel_index, 0);
    n = 0;
    while (words_q.size() < 3 && n < 200) begin
      tick(1);
      n++;
    end
    check("rst_words", (words_q.size() >= 3) ? 1 : 0, 1);
    check("rst_w0", words_q[0], 16'h0000);
    check("rst_w1", words_q[1], 16'h0001);
    check("rst_w2", words_q[2], 16'h0002);

    // Whole-run protocol invariants
    check("fb_sp_overlap", overlap_cnt, 0);
    check("sclk_while_cs_high", sclk_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
